// File: rtl/pc_fetch_unit.sv
// RV32I program counter and fetch sequencer: IDLE -> FETCH (req/ready) -> EXEC (pc_en) -> FETCH.
// Optional misaligned-target trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_fetch_unit #(
    parameter int unsigned XLEN         = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            next_pc_src_i,
    input  logic [XLEN-1:0] alu_res_i,
    input  logic            pc_en_i,
    input  logic            imem_ready_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] retired_o,
    output logic            trap_o,
    output logic [XLEN-1:0] trap_pc_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        TRAP  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   retired_q, retired_d;
    logic              imem_req_q, imem_req_d;
    logic              instr_valid_q, instr_valid_d;
    logic [XLEN-1:0]   target_c;
`ifdef PC_MISALIGN_TRAP_EN
    logic              trap_q, trap_d;
    logic [XLEN-1:0]   trap_pc_q, trap_pc_d;
`endif

    assign pc_plus4_o = pc_q + XLEN'(4);

    // JALR-style bit0 clear on the taken target
    assign target_c = next_pc_src_i ? (alu_res_i & ~XLEN'(1)) : pc_plus4_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= XLEN'(RESET_VECTOR);
            retired_q     <= '0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            trap_q        <= 1'b0;
            trap_pc_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            retired_q     <= retired_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
`ifdef PC_MISALIGN_TRAP_EN
            trap_q        <= trap_d;
            trap_pc_q     <= trap_pc_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
`ifdef PC_MISALIGN_TRAP_EN
        trap_d    = trap_q;
        trap_pc_d = trap_pc_q;
`endif
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: if (imem_ready_i) state_d = EXEC;
            EXEC: begin
                if (pc_en_i) begin
`ifdef PC_MISALIGN_TRAP_EN
                    if (target_c[1]) begin
                        trap_d    = 1'b1;
                        trap_pc_d = target_c;
                        state_d   = TRAP;
                    end else begin
                        pc_d      = target_c;
                        retired_d = retired_q + XLEN'(1);
                        state_d   = FETCH;
                    end
`else
                    pc_d      = target_c & ~XLEN'(3);
                    retired_d = retired_q + XLEN'(1);
                    state_d   = FETCH;
`endif
                end
            end
            TRAP:    state_d = TRAP;
            default: state_d = IDLE;
        endcase
        // Handshake flags follow the state being entered so they flop alongside it
        imem_req_d    = (state_d == FETCH);
        instr_valid_d = (state_d == EXEC);
    end

    assign imem_req_o    = imem_req_q;
    assign instr_valid_o = instr_valid_q;
    assign pc_o          = pc_q;
    assign imem_addr_o   = pc_q;
    assign retired_o     = retired_q;
`ifdef PC_MISALIGN_TRAP_EN
    assign trap_o        = trap_q;
    assign trap_pc_o     = trap_pc_q;
`else
    assign trap_o        = 1'b0;
    assign trap_pc_o     = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: cycle model plus directed literal checks.
// Honours PC_MISALIGN_TRAP_EN the same way as the design.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        next_pc_src;
    logic [31:0] alu_res;
    logic        pc_en;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic [31:0] retired;
    logic        trap;
    logic [31:0] trap_pc;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // model: phase 0=idle 1=fetching 2=executing 3=trapped
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_ret;
    logic        m_trap;
    logic [31:0] m_tpc;

    pc_fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .next_pc_src_i(next_pc_src),
        .alu_res_i    (alu_res),
        .pc_en_i      (pc_en),
        .imem_ready_i (imem_ready),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .pc_o         (pc),
        .pc_plus4_o   (pc_plus4),
        .instr_valid_o(instr_valid),
        .retired_o    (retired),
        .trap_o       (trap),
        .trap_pc_o    (trap_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        logic [31:0] tgt;
        if (!rst_n) begin
            m_phase <= 0;
            m_pc    <= 32'h0;
            m_ret   <= 32'h0;
            m_trap  <= 1'b0;
            m_tpc   <= 32'h0;
        end else begin
            tgt = next_pc_src ? {alu_res[31:1], 1'b0} : m_pc + 32'd4;
            if (m_phase == 0) m_phase <= 1;
            else if (m_phase == 1 && imem_ready) m_phase <= 2;
            else if (m_phase == 2 && pc_en) begin
`ifdef PC_MISALIGN_TRAP_EN
                if (tgt[1]) begin
                    m_trap  <= 1'b1;
                    m_tpc   <= tgt;
                    m_phase <= 3;
                end else begin
                    m_pc    <= tgt;
                    m_ret   <= m_ret + 32'd1;
                    m_phase <= 1;
                end
`else
                m_pc    <= {tgt[31:2], 2'b00};
                m_ret   <= m_ret + 32'd1;
                m_phase <= 1;
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_imem_req", 32'(imem_req), 32'(m_phase == 1));
            chk("m_instr_valid", 32'(instr_valid), 32'(m_phase == 2));
            chk("m_pc", pc, m_pc);
            chk("m_imem_addr", imem_addr, m_pc);
            chk("m_pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("m_retired", retired, m_ret);
            chk("m_trap", 32'(trap), 32'(m_trap));
            chk("m_trap_pc", trap_pc, m_tpc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // wait for an executable instruction, then retire it with the given next-PC selection
    task automatic exec_instr(input logic src, input logic [31:0] alu);
        int n = 0;
        while (!instr_valid && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL exec_wait: instr_valid never rose within %0d cycles", n);
        end
        pc_en       = 1'b1;
        next_pc_src = src;
        alu_res     = alu;
        tick();
        pc_en       = 1'b0;
        next_pc_src = 1'($urandom_range(0, 1));
        alu_res     = $urandom;
    endtask

    initial begin
        rst_n       = 1'b1;
        next_pc_src = 1'b0;
        alu_res     = 32'h0;
        pc_en       = 1'b0;
        imem_ready  = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_retired", retired, 32'h0);
        chk("rst_trap", 32'(trap), 32'h0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // sequential step
        exec_instr(1'b0, 32'h0);
        chk("t1_pc", pc, 32'h4);
        chk("t1_retired", retired, 32'h1);
        chk("t1_req", 32'(imem_req), 32'h1);

        // jump with bit0 cleared
        exec_instr(1'b1, 32'h0000_0010);
        chk("t2_pc_pre", pc, 32'h10);
        exec_instr(1'b1, 32'h0000_0101);
        chk("t2_pc", pc, 32'h100);

        // stalled fetch ignores pc_en
        imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pc_en       = 1'(i % 2 == 0);
            next_pc_src = 1'b1;
            alu_res     = 32'h200;
            tick();
            chk("t3_req", 32'(imem_req), 32'h1);
            chk("t3_pc", pc, 32'h100);
            chk("t3_valid", 32'(instr_valid), 32'h0);
        end
        pc_en      = 1'b0;
        imem_ready = 1'b1;

        // wrap-around
        exec_instr(1'b1, 32'hFFFF_FFFC);
        chk("t4_pc_pre", pc, 32'hFFFF_FFFC);
        exec_instr(1'b0, 32'h0);
        chk("t4_pc", pc, 32'h0);
        chk("t4_retired", retired, 32'h5);

        // async reset mid-fetch
        exec_instr(1'b1, 32'h0000_0040);
        chk("t5_pc_pre", pc, 32'h40);
        chk("t5_req_pre", 32'(imem_req), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_req", 32'(imem_req), 32'h0);
        chk("t5_pc", pc, 32'h0);
        chk("t5_retired", retired, 32'h0);
        tick();
        rst_n = 1'b1;

        // misaligned target
        exec_instr(1'b1, 32'h0000_0022);
`ifdef PC_MISALIGN_TRAP_EN
        chk("t6_trap", 32'(trap), 32'h1);
        chk("t6_trap_pc", trap_pc, 32'h22);
        chk("t6_pc", pc, 32'h0);
        chk("t6_retired", retired, 32'h0);
        for (int i = 0; i < 3; i++) begin
            pc_en = 1'b1;
            tick();
            chk("t6_stuck_req", 32'(imem_req), 32'h0);
            chk("t6_stuck_valid", 32'(instr_valid), 32'h0);
        end
        pc_en = 1'b0;
`else
        chk("t6_pc", pc, 32'h20);
        chk("t6_trap", 32'(trap), 32'h0);
        chk("t6_retired", retired, 32'h1);
`endif

        // mixed traffic with random fetch latency against the model
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 24; i++) begin
            imem_ready = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
            imem_ready = 1'b1;
            exec_instr(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFD);
        end
        chk("mix_retired", retired, 32'd24);
        tick();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
